// File: rtl/hazard_scoreboard.sv
// D-stage stall controller: per-register Tnew countdown scoreboard,
// MDU busy counter and a saturating stall-cycle counter.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   id_valid, flush       D holds an instruction / kill it this cycle
//   id_rs/rt, id_use_*,   source registers, read enables and Tuse
//   id_tuse_*
//   id_wr, id_wa, id_tnew destination write and its Tnew
//   id_md_start/div/use   MDU start, div select, any HI/LO access
//   stall                 freeze PC/IF-ID, bubble ID-EX (combinational)
//   md_busy               MDU counter nonzero
//   stall_cnt             saturating count of stalled cycles
module hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int TW       = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int SCW      = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           id_valid,
    input  logic [AW-1:0]  id_rs,
    input  logic [AW-1:0]  id_rt,
    input  logic           id_use_rs,
    input  logic           id_use_rt,
    input  logic [TW-1:0]  id_tuse_rs,
    input  logic [TW-1:0]  id_tuse_rt,
    input  logic           id_wr,
    input  logic [AW-1:0]  id_wa,
    input  logic [TW-1:0]  id_tnew,
    input  logic           id_md_start,
    input  logic           id_md_div,
    input  logic           id_md_use,
    input  logic           flush,
    output logic           stall,
    output logic           md_busy,
    output logic [SCW-1:0] stall_cnt
);

    localparam int MAXL = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int MW   = $clog2(MAXL + 1);

    logic [TW-1:0] cnt [NREG];
    logic [MW-1:0] md_cnt;

    logic hz_rs;
    logic hz_rt;
    logic hz_md;
    logic issue;
    logic wr_en;

    // Compares use the pre-update counts, so an instruction that reads
    // and writes the same register sees the old pending value.
    always_comb begin
        hz_rs = id_use_rs && (id_rs != '0) && (cnt[id_rs] > id_tuse_rs);
        hz_rt = id_use_rt && (id_rt != '0) && (cnt[id_rt] > id_tuse_rt);
        hz_md = id_md_use && md_busy;
    end

    assign md_busy = (md_cnt != '0);
    assign stall   = id_valid && !flush && (hz_rs || hz_rt || hz_md);
    assign issue   = id_valid && !flush && !stall;
    assign wr_en   = issue && id_wr && (id_wa != '0);

    // A new write overwrites any pending count for its register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (wr_en && (id_wa == AW'(r))) begin
                    cnt[r] <= id_tnew;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
        end
    end

    // A start while busy is stalled by hz_md, so it never restarts
    // a running operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_cnt <= '0;
        end else if (issue && id_md_start) begin
            md_cnt <= id_md_div ? MW'(DIV_LAT) : MW'(MULT_LAT);
        end else if (md_busy) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus
// randomized traffic against a ready-time reference model.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        id_valid, id_use_rs, id_use_rt, id_wr;
    logic [4:0]  id_rs, id_rt, id_wa;
    logic [1:0]  id_tuse_rs, id_tuse_rt, id_tnew;
    logic        id_md_start, id_md_div, id_md_use, flush;
    logic        stall, md_busy, stall4, busy4;
    logic [31:0] stall_cnt;
    logic [3:0]  sc4;

    int checks = 0;
    int errors = 0;

    // Model: absolute cycle at which each register / the MDU is free.
    longint now = 0;
    longint rdy [32];
    longint mdfree = 0;
    longint sc = 0;
    logic   last_stall;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_tuse_rs(id_tuse_rs), .id_tuse_rt(id_tuse_rt),
        .id_wr(id_wr), .id_wa(id_wa), .id_tnew(id_tnew),
        .id_md_start(id_md_start), .id_md_div(id_md_div),
        .id_md_use(id_md_use), .flush(flush),
        .stall(stall), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    hazard_scoreboard #(.SCW(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_tuse_rs(id_tuse_rs), .id_tuse_rt(id_tuse_rt),
        .id_wr(id_wr), .id_wa(id_wa), .id_tnew(id_tnew),
        .id_md_start(id_md_start), .id_md_div(id_md_div),
        .id_md_use(id_md_use), .flush(flush),
        .stall(stall4), .md_busy(busy4), .stall_cnt(sc4)
    );

    task automatic chk(input string tag, input longint obs,
                       input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint pend(input int r);
        return (r != 0 && rdy[r] > now) ? rdy[r] - now : 0;
    endfunction

    function automatic longint sat4(input longint v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 32; r++) rdy[r] = 0;
        mdfree = 0;
        sc = 0;
    endtask

    task automatic ins(input logic v,
                       input logic [4:0] rs, input logic urs,
                       input logic [1:0] trs,
                       input logic [4:0] rt, input logic urt,
                       input logic [1:0] trt,
                       input logic wr, input logic [4:0] wa,
                       input logic [1:0] tn,
                       input logic ms, input logic md, input logic mu,
                       input logic fl);
        id_valid = v;
        id_rs = rs; id_use_rs = urs; id_tuse_rs = trs;
        id_rt = rt; id_use_rt = urt; id_tuse_rt = trt;
        id_wr = wr; id_wa = wa; id_tnew = tn;
        id_md_start = ms; id_md_div = md; id_md_use = mu;
        flush = fl;
    endtask

    task automatic idle();
        ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rnd_inputs();
        id_valid    = ($urandom_range(9) != 0);
        id_rs       = 5'($urandom_range(7));
        id_rt       = 5'($urandom_range(7));
        id_use_rs   = 1'($urandom_range(1));
        id_use_rt   = 1'($urandom_range(1));
        id_tuse_rs  = 2'($urandom_range(3));
        id_tuse_rt  = 2'($urandom_range(3));
        id_wr       = 1'($urandom_range(1));
        id_wa       = 5'($urandom_range(7));
        id_tnew     = 2'($urandom_range(3));
        id_md_start = ($urandom_range(15) == 0);
        id_md_div   = 1'($urandom_range(1));
        id_md_use   = id_md_start | ($urandom_range(4) == 0);
        flush       = ($urandom_range(9) == 0);
    endtask

    // Entered at posedge+1 with inputs set; leaves at next posedge+1.
    task automatic step();
        logic hz, es, ei;
        int k;
        #1;
        hz = (id_use_rs && id_rs != 0 && pend(id_rs) > id_tuse_rs)
          || (id_use_rt && id_rt != 0 && pend(id_rt) > id_tuse_rt)
          || (id_md_use && mdfree > now);
        es = id_valid && !flush && hz;
        ei = id_valid && !flush && !hz;
        chk("stall", stall, es);
        chk("md_busy", md_busy, mdfree > now);
        chk("stall_cnt", stall_cnt, sc);
        chk("stall_cnt4", sc4, sat4(sc));
        last_stall = stall;
        @(posedge clk);
        now++;
        if (es) sc++;
        if (ei && id_wr && id_wa != 0) rdy[id_wa] = now + id_tnew;
        if (ei && id_md_start) mdfree = now + (id_md_div ? 10 : 5);
        #1;
        k = $urandom_range(31);
        chk("cnt_probe", dut.cnt[k], pend(k));
    endtask

    // Counts stalled cycles until the presented instruction leaves D.
    task automatic run(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!last_stall) break;
            n++;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        rnd_inputs();
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_busy", md_busy, 0);
        chk("rst_sc", stall_cnt, 0);
        model_clear();
        @(posedge clk);
        now++;
        #1;
        for (int r = 0; r < 32; r++) chk("rst_cnt", dut.cnt[r], 0);
        chk("rst_sc4", sc4, 0);
        reset_n = 1'b1;
    endtask

    initial begin
        int n;
        idle();
        model_clear();
        @(posedge clk);
        #1;
        do_reset();

        idle(); step();
        ins(1, 0, 0, 0, 0, 0, 0, 1, 8, 2, 0, 0, 0, 0); step();
        ins(1, 8, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); run(n);
        chk("loaduse_tuse1", n, 1);
        idle(); repeat (3) step();
        ins(1, 0, 0, 0, 0, 0, 0, 1, 8, 2, 0, 0, 0, 0); step();
        ins(1, 8, 1, 2, 0, 0, 0, 1, 9, 1, 0, 0, 0, 0); run(n);
        chk("loaduse_tuse2", n, 0);

        ins(1, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0); step();
        ins(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0); run(n);
        chk("reg0", n, 0);

        ins(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0); step();
        ins(1, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 1, 0); run(n);
        chk("mult_mfhi", n, 5);
        ins(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0); step();
        ins(1, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 1, 0); run(n);
        chk("div_mflo", n, 10);
        ins(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0); step();
        ins(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0); run(n);
        chk("div_div", n, 10);
        ins(1, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 1, 0); run(n);
        chk("div_div_mflo", n, 10);

        ins(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0); step();
        ins(1, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 1, 0);
        step(); step();
        reset_n = 1'b0;
        #1;
        chk("async_busy", md_busy, 0);
        chk("async_stall", stall, 0);
        chk("async_sc", stall_cnt, 0);
        model_clear();
        #1;
        reset_n = 1'b1;
        step();

        idle(); step();
        repeat (2) begin
            ins(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0); step();
            ins(1, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 1, 0); run(n);
        end
        chk("sat_sc4", sc4, 15);
        chk("sat_sc32", stall_cnt, 20);

        ins(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0); step();
        ins(1, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 1, 1); step();
        chk("flush_sc32", stall_cnt, 20);
        step();
        chk("flush_stall", stall, 0);
        chk("flush_sc32b", stall_cnt, 20);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(249) == 0) begin
                do_reset();
            end else begin
                rnd_inputs();
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
